wb_dmem_master: RTL and testbench

Synthesizable Wishbone classic data-bus initiator (load/store unit back end) for custom_riscv_core. It takes one load or store request at a time from the core's MEM stage and drives dwb_* cycles toward a memory/peripheral responder. It forms the byte lanes, waits for ack/err or a timeout, then returns aligned, sign/zero-extended load data or a fault status. It is the master counterpart to the testbench memory responders.

---
 rtl/wb_dmem_master_pkg.sv | 24 ++
 rtl/wb_dmem_lane.sv | 64 ++++++
 rtl/wb_dmem_master.sv | 192 +++++++++++++++++++
 tb/tb_wb_dmem_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dmem_master_pkg.sv
// Shared definitions for the Wishbone data-bus initiator.
//   - RV32 load/store funct3 encodings
//   - FSM state encoding used by wb_dmem_master
package wb_dmem_master_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/wb_dmem_lane.sv
// Byte-lane steering for the data-bus initiator (purely combinational).
// Ports:
//   we, funct3, addr_lo  - access kind, size and byte offset within the word
//   wdata                - LSB-justified store data
//   rdata                - raw bus read word
//   sel                  - Wishbone byte selects
//   wdata_rep            - store data replicated across all lanes
//   rdata_ext            - load data shifted down and sign/zero-extended
//   misaligned, illegal  - request classification (illegal wins)
module wb_dmem_lane
   import wb_dmem_master_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  sel,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misaligned,
   output logic        illegal
);

   logic [31:0] shifted;

   // NOTE: every output gets a default first so no path leaves one unassigned
   // and a latch can never be inferred.
   always_comb begin
      sel        = 4'b0000;
      wdata_rep  = wdata;
      rdata_ext  = rdata;
      misaligned = 1'b0;
      shifted    = rdata >> {addr_lo, 3'b000};

      if (we) illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
      else    illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});

      // funct3[1:0] is the access size, funct3[2] selects zero-extension
      unique case (funct3[1:0])
         2'd0: begin
            sel       = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = funct3[2] ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'd1: begin
            sel        = 4'b0011 << addr_lo;
            wdata_rep  = {2{wdata[15:0]}};
            rdata_ext  = funct3[2] ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
            misaligned = addr_lo[0];
         end
         default: begin
            sel        = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
      endcase

      // An illegal funct3 is reported as an error, never as misaligned
      if (illegal) misaligned = 1'b0;
   end

endmodule

// File: rtl/wb_dmem_master.sv
// Wishbone classic data-bus initiator (load/store back end of the core).
// Accepts one request at a time, runs one bus cycle, returns a single-cycle
// response with extended load data or a fault status.
// Ports:
//   clk, rst_n                         - clock, asynchronous active-low reset
//   req_*                              - request from MEM stage (valid/ready)
//   resp_*                             - one-cycle completion and status
//   busy                               - transaction in flight
//   dwb_*                              - Wishbone classic master interface
module wb_dmem_master
   import wb_dmem_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        resp_misaligned,
   output logic [31:0] resp_addr,
   output logic        busy,
   output logic [31:0] dwb_adr_o,
   output logic [31:0] dwb_dat_o,
   output logic [3:0]  dwb_sel_o,
   output logic        dwb_we_o,
   output logic        dwb_cyc_o,
   output logic        dwb_stb_o,
   input  logic [31:0] dwb_dat_i,
   input  logic        dwb_ack_i,
   input  logic        dwb_err_i
);

   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       dat_q, dat_d;
   logic [3:0]        sel_q, sel_d;
   logic              cyc_q, cyc_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              mis_q, mis_d;

   logic              idle;
   logic              lane_we;
   logic [2:0]        lane_f3;
   logic [1:0]        lane_lo;
   logic [3:0]        lane_sel;
   logic [31:0]       lane_wdata;
   logic [31:0]       lane_rdata;
   logic              lane_mis;
   logic              lane_ill;

   assign idle    = (state_q == ST_IDLE);
   assign cnt_inc = cnt_q + 1'b1;

   // Classify the incoming request while idle; afterwards extract load data
   // using the latched access kind and offset.
   assign lane_we = idle ? req_we         : we_q;
   assign lane_f3 = idle ? req_funct3     : f3_q;
   assign lane_lo = idle ? req_addr[1:0]  : addr_q[1:0];

   wb_dmem_lane u_lane (
      .we         (lane_we),
      .funct3     (lane_f3),
      .addr_lo    (lane_lo),
      .wdata      (req_wdata),
      .rdata      (dwb_dat_i),
      .sel        (lane_sel),
      .wdata_rep  (lane_wdata),
      .rdata_ext  (lane_rdata),
      .misaligned (lane_mis),
      .illegal    (lane_ill)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      cyc_d   = cyc_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mis_d   = mis_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               dat_d   = lane_wdata;
               sel_d   = lane_sel;
               rdata_d = '0;
               err_d   = lane_ill;
               mis_d   = lane_mis;
               cnt_d   = '0;
               if (lane_ill || lane_mis) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_BUS;
                  cyc_d   = 1'b1;
               end
            end
         end
         ST_BUS: begin
            // err wins over a simultaneous ack; data is taken on this edge
            // because the responder may only drive it while stb is high.
            if (dwb_err_i) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else if (dwb_ack_i) begin
               cyc_d   = 1'b0;
               cnt_d   = '0;
               rdata_d = we_q ? '0 : lane_rdata;
               state_d = ST_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TMO_LIMIT)) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         dat_q   <= '0;
         sel_q   <= 4'b0000;
         cyc_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         cyc_q   <= cyc_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign req_ready       = idle;
   assign busy            = !idle;
   assign resp_valid      = (state_q == ST_RESP);
   assign resp_rdata      = resp_valid ? rdata_q : '0;
   assign resp_err        = resp_valid & err_q;
   assign resp_misaligned = resp_valid & mis_q;
   assign resp_addr       = addr_q;

   assign dwb_adr_o = {addr_q[31:2], 2'b00};
   assign dwb_dat_o = dat_q;
   assign dwb_sel_o = sel_q;
   assign dwb_we_o  = we_q;
   assign dwb_cyc_o = cyc_q;
   assign dwb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_dmem_master.sv
// Self-checking bench for wb_dmem_master: directed cases plus randomized
// load/store traffic against a word-array reference model.
module tb_wb_dmem_master;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, resp_misaligned, busy;
   logic [31:0] resp_rdata, resp_addr;
   logic [31:0] dwb_adr_o, dwb_dat_o, dwb_dat_i;
   logic [3:0]  dwb_sel_o;
   logic        dwb_we_o, dwb_cyc_o, dwb_stb_o, dwb_ack_i, dwb_err_i;

   int n_checks = 0;
   int n_fail   = 0;

   // Responder control: rsp_delay = stb cycles until reply (0 = never),
   // rsp_mode 0 = ack, 1 = err, 2 = ack+err
   int rsp_delay = 2;
   int rsp_mode  = 0;

   logic [31:0] slv_mem [16];
   logic [31:0] ref_mem [16];

   wb_dmem_master #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_we          (req_we),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_err        (resp_err),
      .resp_misaligned (resp_misaligned),
      .resp_addr       (resp_addr),
      .busy            (busy),
      .dwb_adr_o       (dwb_adr_o),
      .dwb_dat_o       (dwb_dat_o),
      .dwb_sel_o       (dwb_sel_o),
      .dwb_we_o        (dwb_we_o),
      .dwb_cyc_o       (dwb_cyc_o),
      .dwb_stb_o       (dwb_stb_o),
      .dwb_dat_i       (dwb_dat_i),
      .dwb_ack_i       (dwb_ack_i),
      .dwb_err_i       (dwb_err_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Memory responder, updated mid-cycle; read data is only meaningful in
   // the cycle ack is presented, random otherwise.
   initial begin : responder
      int waits;
      waits     = 0;
      dwb_ack_i = 1'b0;
      dwb_err_i = 1'b0;
      dwb_dat_i = 32'h0;
      forever begin
         @(negedge clk);
         if (dwb_cyc_o && dwb_stb_o && !dwb_ack_i && !dwb_err_i) begin
            waits++;
            if (rsp_delay != 0 && waits == rsp_delay) begin
               dwb_ack_i = (rsp_mode != 1);
               dwb_err_i = (rsp_mode != 0);
               if (rsp_mode == 0 && dwb_we_o) begin
                  for (int b = 0; b < 4; b++)
                     if (dwb_sel_o[b]) slv_mem[dwb_adr_o[5:2]][8*b +: 8] = dwb_dat_o[8*b +: 8];
               end
               dwb_dat_i = (rsp_mode == 0 && !dwb_we_o) ? slv_mem[dwb_adr_o[5:2]] : $urandom;
            end
         end else begin
            waits     = 0;
            dwb_ack_i = 1'b0;
            dwb_err_i = 1'b0;
            dwb_dat_i = $urandom;
         end
      end
   end

   // One complete request with the model's expectations checked.
   task automatic run_txn(input string tag, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int mode, input int delay, output logic [31:0] rd);
      bit          ill, mis, bus, e_err, unstable;
      int          nb, lane, sel_int, stb_n, resp_n, resp_k, e_k, e_stb;
      logic [31:0] e_dat, e_rdata, sh, s_adr, s_dat;
      logic [3:0]  e_sel, s_sel;
      logic        s_we, busy_k1, r_err, r_mis;
      logic [31:0] r_rdata, r_addr;

      // Reference expectations from the access rules
      ill     = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
      nb      = 1 << f3[1:0];
      lane    = int'(addr[1:0]);
      mis     = !ill && ((int'(addr[3:0]) % nb) != 0);
      bus     = !ill && !mis;
      sel_int = ((1 << nb) - 1) << lane;
      e_sel   = sel_int[3:0];
      e_dat   = (nb == 1) ? {24'h0, wdata[7:0]} * 32'h01010101 :
                (nb == 2) ? {16'h0, wdata[15:0]} * 32'h00010001 : wdata;
      e_err   = ill || (bus && (mode != 0 || delay == 0));
      e_stb   = !bus ? 0 : (delay == 0 ? TMO : delay);
      e_k     = e_stb + 1;
      e_rdata = 32'h0;
      if (bus && !e_err && !we) begin
         sh = ref_mem[addr[5:2]] >> (8 * lane);
         if (nb == 1)      e_rdata = f3[2] ? {24'h0, sh[7:0]}  : 32'($signed(sh[7:0]));
         else if (nb == 2) e_rdata = f3[2] ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
         else              e_rdata = ref_mem[addr[5:2]];
      end
      if (bus && !e_err && we)
         for (int b = 0; b < nb; b++) ref_mem[addr[5:2]][8*(lane+b) +: 8] = wdata[8*b +: 8];

      rsp_mode  = mode;
      rsp_delay = delay;
      @(negedge clk);
      check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      // Scramble request inputs to prove the DUT latched them
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;

      stb_n = 0; resp_n = 0; resp_k = 0; unstable = 0; busy_k1 = 1'b0;
      s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0;
      r_err = 1'b0; r_mis = 1'b0; r_rdata = '0; r_addr = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) busy_k1 = busy;
         if (dwb_cyc_o !== dwb_stb_o) unstable = 1;
         if (dwb_stb_o) begin
            if (stb_n == 0) begin
               s_adr = dwb_adr_o; s_dat = dwb_dat_o; s_sel = dwb_sel_o; s_we = dwb_we_o;
            end else if ({dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o} !== {s_adr, s_dat, s_sel, s_we}) begin
               unstable = 1;
            end
            stb_n++;
         end
         if (resp_valid) begin
            resp_n++;
            if (resp_n == 1) begin
               resp_k = k; r_err = resp_err; r_mis = resp_misaligned;
               r_rdata = resp_rdata; r_addr = resp_addr;
            end
         end
         if (resp_n > 0 && k >= resp_k + 2) break;
      end

      check({tag, ".busy"},    {31'h0, busy_k1}, 32'h1);
      check({tag, ".resp_n"},  resp_n, 1);
      check({tag, ".latency"}, resp_k, e_k);
      check({tag, ".stb_n"},   stb_n, e_stb);
      check({tag, ".stable"},  {31'h0, unstable}, 32'h0);
      check({tag, ".err"},     {31'h0, r_err}, {31'h0, e_err});
      check({tag, ".mis"},     {31'h0, r_mis}, {31'h0, mis});
      check({tag, ".rdata"},   r_rdata, e_rdata);
      check({tag, ".addr"},    r_addr, addr);
      if (bus) begin
         check({tag, ".adr"}, s_adr, {addr[31:2], 2'b00});
         check({tag, ".sel"}, {28'h0, s_sel}, {28'h0, e_sel});
         check({tag, ".we"},  {31'h0, s_we}, {31'h0, we});
         if (we) check({tag, ".dat"}, s_dat, e_dat);
      end
      rd = r_rdata;
   endtask

   initial begin : stimulus
      logic [31:0] rd;
      int          cnt, r, dly, md;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;

      for (int i = 0; i < 16; i++) begin
         slv_mem[i] = $urandom;
         ref_mem[i] = slv_mem[i];
      end
      slv_mem[0] = 32'hDEADBEEF;
      ref_mem[0] = 32'hDEADBEEF;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;

      // Reset values
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.ready", {31'h0, req_ready}, 32'h1);
      check("rst.busy",  {31'h0, busy}, 32'h0);
      check("rst.cyc",   {31'h0, dwb_cyc_o}, 32'h0);
      check("rst.resp",  {28'h0, resp_valid, resp_err, resp_misaligned, 1'b0}, 32'h0);
      check("rst.rdata", resp_rdata, 32'h0);
      rst_n = 1'b1;

      // Aligned word load
      run_txn("lw", 1'b0, 3'd2, 32'h0000_1000, 32'h0, 0, 2, rd);
      check("lw.const", rd, 32'hDEADBEEF);

      // Stores with lane replication
      run_txn("sb", 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, 2, rd);
      run_txn("sh", 1'b1, 3'd1, 32'h0000_1002, 32'h0000_1234, 0, 1, rd);
      run_txn("lw_st", 1'b0, 3'd2, 32'h0000_1000, 32'h0, 0, 3, rd);
      check("lw_st.const", rd, 32'h1234BEEF);

      // Extension of sub-word loads
      run_txn("sw", 1'b1, 3'd2, 32'h0000_1000, 32'h1234_8056, 0, 2, rd);
      run_txn("lb0",  1'b0, 3'd0, 32'h0000_1000, 32'h0, 0, 2, rd);
      check("lb0.const", rd, 32'h0000_0056);
      run_txn("lb1",  1'b0, 3'd0, 32'h0000_1001, 32'h0, 0, 1, rd);
      check("lb1.const", rd, 32'hFFFF_FF80);
      run_txn("lhu0", 1'b0, 3'd5, 32'h0000_1000, 32'h0, 0, 2, rd);
      check("lhu0.const", rd, 32'h0000_8056);
      run_txn("lh2",  1'b0, 3'd1, 32'h0000_1002, 32'h0, 0, 3, rd);
      check("lh2.const", rd, 32'h0000_1234);

      // Misaligned and illegal requests never reach the bus
      run_txn("lw_mis", 1'b0, 3'd2, 32'h0000_1002, 32'h0, 0, 2, rd);
      run_txn("sh_mis", 1'b1, 3'd1, 32'h0000_1001, 32'hFFFF, 0, 2, rd);
      run_txn("ld_ill", 1'b0, 3'd3, 32'h0000_1000, 32'h0, 0, 2, rd);

      // Bus error, ack+err, timeout, then a normal access
      run_txn("err",     1'b0, 3'd2, 32'h0000_1004, 32'h0, 1, 1, rd);
      run_txn("ack_err", 1'b0, 3'd2, 32'h0000_1008, 32'h0, 2, 1, rd);
      run_txn("tmo",     1'b0, 3'd2, 32'h0000_100C, 32'h0, 0, 0, rd);
      run_txn("post_tmo", 1'b0, 3'd2, 32'h0000_1000, 32'h0, 0, 2, rd);

      // Asynchronous reset in the middle of a bus cycle
      rsp_delay = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_1010;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("arst.pre_cyc", {31'h0, dwb_cyc_o}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst.cyc",   {31'h0, dwb_cyc_o}, 32'h0);
      check("arst.stb",   {31'h0, dwb_stb_o}, 32'h0);
      check("arst.resp",  {31'h0, resp_valid}, 32'h0);
      check("arst.ready", {31'h0, req_ready}, 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid || dwb_cyc_o) cnt++;
      end
      check("arst.quiet", cnt, 0);
      run_txn("arst.lw", 1'b0, 3'd2, 32'h0000_1000, 32'h0, 0, 2, rd);
      check("arst.lw.const", rd, 32'h1234_8056);

      // Randomized traffic against the reference model
      for (int t = 0; t < 40; t++) begin
         we = 1'($urandom);
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 >= 3'd3) f3 = f3 + 3'd1;
         end
         addr = 32'h0000_1000 + 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'($urandom_range(0, 3));
         r   = $urandom_range(0, 9);
         dly = $urandom_range(1, 3);
         md  = 0;
         if (r == 0) md = 1;
         else if (r == 1) md = 2;
         else if (r == 2) dly = 0;
         run_txn($sformatf("rnd%0d", t), we, f3, addr, $urandom, md, dly, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
